// File: rtl/mitchell_div_pipe.sv
// Signed Mitchell log divider: q = x/y approximated as antilog(log2|x| - log2|y|), Q8.8 result.
// Latency: 3 cycles accept-to-result, 1 result/cycle when downstream is ready.
// Backpressure: each stage loads when its successor is empty or advancing; in_ready_o=0 only when all 3 stages hold data and out_ready_i=0.
// Optional build macro MITCHELL_DIV_ROUND_EN: round half-up in the antilog right-shift branch (default truncates).
module mitchell_div_pipe (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [16:0] q_o,
    output logic        dz_o
);

    typedef struct packed {
        logic [9:0] la;     // {k, f} of |x|
        logic [9:0] lb;     // {k, f} of |y|
        logic       sign;
        logic       zx;
        logic       zy;
    } s1_t;

    typedef struct packed {
        logic [3:0] e;      // signed integer part of the log difference
        logic [6:0] f;      // fractional part of the log difference
        logic       sign;
        logic       zx;
        logic       zy;
    } s2_t;

    // 8-bit magnitude; -256 cannot be represented and saturates to 255
    function automatic logic [7:0] mag8(input logic [8:0] v);
        logic [8:0] a;
        a = v[8] ? (~v + 9'd1) : v;
        return a[8] ? 8'hFF : a[7:0];
    endfunction

    // Mitchell log2: leading-one index as integer part, bits below it as fraction
    function automatic logic [9:0] log_approx(input logic [7:0] m);
        logic [2:0] k;
        logic [7:0] n;
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) k = 3'(i);
        end
        n = m << (3'd7 - k);
        return {k, n[6:0]};
    endfunction

    logic        v1_q, v2_q, v3_q;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    logic [16:0] q_q, q_d;
    logic        dz_q, dz_d;
    logic        ld1, ld2, ld3;

    // Load enables ripple back from the output so a full pipe can still accept while retiring
    always_comb begin
        ld3        = ~v3_q | out_ready_i;
        ld2        = ~v2_q | ld3;
        ld1        = ~v1_q | ld2;
        in_ready_o = ld1;
    end

    // Stage 1 next state: operand magnitudes and their logs
    always_comb begin
        logic [7:0] ma, mb;
        ma      = mag8(x_i);
        mb      = mag8(y_i);
        s1_d    = '0;
        s1_d.la = log_approx(ma);
        s1_d.lb = log_approx(mb);
        s1_d.sign = x_i[8] ^ y_i[8];
        s1_d.zx = (ma == 8'd0);
        s1_d.zy = (mb == 8'd0);
    end

    // Stage 2 next state: log difference split into exponent and fraction
    always_comb begin
        logic [10:0] diff;
        diff      = {1'b0, s1_q.la} - {1'b0, s1_q.lb};
        s2_d      = '0;
        s2_d.e    = diff[10:7];
        s2_d.f    = diff[6:0];
        s2_d.sign = s1_q.sign;
        s2_d.zx   = s1_q.zx;
        s2_d.zy   = s1_q.zy;
    end

    // Stage 3 next state: antilog shift, special cases, sign application
    always_comb begin
        logic [7:0]  m;
        logic [15:0] mq;
        logic [3:0]  lsh;
        logic [2:0]  rsh;
        m    = {1'b1, s2_q.f};
        mq   = 16'd0;
        lsh  = s2_q.e + 4'd1;       // valid when e >= -1: 0..8
        rsh  = ~s2_q.e[2:0];        // -(e+1) when e <= -2: 1..7
        dz_d = 1'b0;
        if (!s2_q.e[3] || s2_q.e == 4'hF) begin
            mq = 16'(m) << lsh;
        end else begin
`ifdef MITCHELL_DIV_ROUND_EN
            mq = {8'h00, m >> rsh} + {15'd0, m[rsh - 3'd1]};
`else
            mq = {8'h00, m >> rsh};
`endif
        end
        if (s2_q.zy) begin
            mq   = 16'hFFFF;
            dz_d = 1'b1;
        end else if (s2_q.zx) begin
            mq   = 16'd0;
        end
        q_d = s2_q.sign ? (17'd0 - {1'b0, mq}) : {1'b0, mq};
    end

    // Pipeline registers; data only captured when a valid item moves in
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            q_q  <= 17'd0;
            dz_q <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid_i;
                if (in_valid_i) s1_q <= s1_d;
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) s2_q <= s2_d;
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    q_q  <= q_d;
                    dz_q <= dz_d;
                end
            end
        end
    end

    assign out_valid_o = v3_q;
    assign q_o         = q_q;
    assign dz_o        = dz_q;

endmodule
